// File: rtl/fir_128_mdc_kernel_ctrl_pkg.sv
// rtl/fir_128_mdc_kernel_ctrl_pkg.sv - shared types and constants for the FIR_128_MDC kernel controller
//
// Contents:
//   FIR_128_MDC_CNT_LEN / FIR_128_MDC_CNT_W : maximum beat count and counter width
//   ctrl_engine_t   : clear / enable / start / cnt_limit_y_V from the control FSM
//   flags_engine_t  : cnt_y_V / done / ready back to the control FSM
//   state_kctrl_t   : kernel controller states
package fir_128_mdc_package;

  localparam int FIR_128_MDC_CNT_LEN = 1024;
  localparam int FIR_128_MDC_CNT_W   = $clog2(FIR_128_MDC_CNT_LEN) + 1;

  typedef struct packed {
    logic                         clear;
    logic                         enable;
    logic                         start;
    logic [FIR_128_MDC_CNT_W-1:0] cnt_limit_y_V;
  } ctrl_engine_t;

  typedef struct packed {
    logic [FIR_128_MDC_CNT_W-1:0] cnt_y_V;
    logic                         done;
    logic                         ready;
  } flags_engine_t;

  typedef enum logic [1:0] {
    KCTRL_IDLE,
    KCTRL_RUN,
    KCTRL_DONE
  } state_kctrl_t;

endpackage

// File: rtl/fir_128_mdc_y_V_skid.sv
// rtl/fir_128_mdc_y_V_skid.sv - 2-entry valid/ready skid buffer for the y_V stream
//
// Ports:
//   clk_i, rst_ni            : clock, asynchronous active-low reset
//   clear_i                  : synchronous flush of both entries
//   in_tdata_i/in_tvalid_i   : upstream beat
//   in_tready_o              : buffer not full (registered, so the writer sees no comb path)
//   out_tdata_o/out_tvalid_o : registered head of the buffer
//   out_tready_i             : downstream accept
module fir_128_mdc_y_V_skid #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  clear_i,
  input  logic [DATA_WIDTH-1:0] in_tdata_i,
  input  logic                  in_tvalid_i,
  output logic                  in_tready_o,
  output logic [DATA_WIDTH-1:0] out_tdata_o,
  output logic                  out_tvalid_o,
  input  logic                  out_tready_i
);

  logic [DATA_WIDTH-1:0] mem [2];
  logic                  wr_ptr_q;
  logic                  rd_ptr_q;
  logic [1:0]            count_q;
  logic                  push;
  logic                  pop;

  assign in_tready_o  = (count_q != 2'd2);
  assign out_tvalid_o = (count_q != 2'd0);
  assign out_tdata_o  = mem[rd_ptr_q];
  assign push         = in_tvalid_i & in_tready_o;
  assign pop          = out_tvalid_o & out_tready_i;

  // Two entries let a simultaneous push and pop keep one beat per cycle
  // while in_tready_o depends only on registered occupancy.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else if (clear_i) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (push) wr_ptr_q <= ~wr_ptr_q;
      if (pop)  rd_ptr_q <= ~rd_ptr_q;
      count_q <= count_q + {1'b0, push} - {1'b0, pop};
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) mem[wr_ptr_q] <= in_tdata_i;
  end

endmodule

// File: rtl/fir_128_mdc_kernel_ctrl.sv
// rtl/fir_128_mdc_kernel_ctrl.sv - engine-side ap_ctrl_hs / ap_fifo bridge for the FIR_128_MDC kernel
//
// Optional build macro: FIR_128_MDC_Y_V_SKID_EN (registers y_V through a 2-entry skid buffer).
//
// Ports:
//   clk_i, rst_ni                       : clock, asynchronous active-low reset
//   ctrl_i / flags_o                    : control FSM request / status
//   x_V_tdata_i/tvalid_i/tready_o       : input stream from the streamer (sink)
//   y_V_tdata_o/tvalid_o/tready_i       : output stream to the streamer (source)
//   ap_rst_o, ap_start_o                : kernel reset (active-high) and start
//   ap_done_i, ap_idle_i, ap_ready_i    : kernel status
//   x_V_dout_o/empty_n_o/read_i         : kernel input ap_fifo
//   y_V_din_i/full_n_o/write_i          : kernel output ap_fifo
module fir_128_mdc_kernel_ctrl
  import fir_128_mdc_package::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_LEN    = FIR_128_MDC_CNT_LEN
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  ctrl_engine_t          ctrl_i,
  output flags_engine_t         flags_o,
  input  logic [DATA_WIDTH-1:0] x_V_tdata_i,
  input  logic                  x_V_tvalid_i,
  output logic                  x_V_tready_o,
  output logic [DATA_WIDTH-1:0] y_V_tdata_o,
  output logic                  y_V_tvalid_o,
  input  logic                  y_V_tready_i,
  output logic                  ap_rst_o,
  output logic                  ap_start_o,
  input  logic                  ap_done_i,
  input  logic                  ap_idle_i,
  input  logic                  ap_ready_i,
  output logic [DATA_WIDTH-1:0] x_V_dout_o,
  output logic                  x_V_empty_n_o,
  input  logic                  x_V_read_i,
  input  logic [DATA_WIDTH-1:0] y_V_din_i,
  output logic                  y_V_full_n_o,
  input  logic                  y_V_write_i
);

  localparam int CW = $clog2(CNT_LEN) + 1;

  state_kctrl_t  state_q;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] limit_q;
  logic [CW-1:0] cnt_inc;
  logic          done_q;
  logic          ap_start_q;
  logic          run_en;
  logic          y_hs;
  logic          unused_status;

  // HLS auto-restart handles ap_done/ap_ready; completion is judged by beat count alone.
  assign unused_status = ^{ap_done_i, ap_ready_i};

  assign run_en   = ctrl_i.enable & (state_q == KCTRL_RUN);
  assign ap_rst_o = ~rst_ni | ctrl_i.clear;
  assign ap_start_o = ap_start_q;

  assign x_V_dout_o    = x_V_tdata_i;
  assign x_V_empty_n_o = x_V_tvalid_i & run_en;
  assign x_V_tready_o  = x_V_read_i & run_en;

`ifdef FIR_128_MDC_Y_V_SKID_EN
  logic skid_tvalid;
  logic skid_tready;

  // Flushing outside RUN drops beats the kernel wrote past the limit.
  fir_128_mdc_y_V_skid #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_y_V_skid (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .clear_i      (ctrl_i.clear | (state_q != KCTRL_RUN)),
    .in_tdata_i   (y_V_din_i),
    .in_tvalid_i  (y_V_write_i & run_en),
    .in_tready_o  (skid_tready),
    .out_tdata_o  (y_V_tdata_o),
    .out_tvalid_o (skid_tvalid),
    .out_tready_i (y_V_tready_i & run_en)
  );

  assign y_V_tvalid_o = skid_tvalid & run_en;
  assign y_V_full_n_o = skid_tready & run_en;
`else
  assign y_V_tdata_o  = y_V_din_i;
  assign y_V_tvalid_o = y_V_write_i & run_en;
  assign y_V_full_n_o = y_V_tready_i & run_en;
`endif

  assign y_hs    = y_V_tvalid_o & y_V_tready_i;
  assign cnt_inc = cnt_q + CW'(1);

  assign flags_o.cnt_y_V = FIR_128_MDC_CNT_W'(cnt_q);
  assign flags_o.done    = done_q;
  assign flags_o.ready   = (state_q == KCTRL_IDLE) & ap_idle_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= KCTRL_IDLE;
      cnt_q      <= '0;
      limit_q    <= '0;
      done_q     <= 1'b0;
      ap_start_q <= 1'b0;
    end else if (ctrl_i.clear) begin
      state_q    <= KCTRL_IDLE;
      cnt_q      <= '0;
      limit_q    <= '0;
      done_q     <= 1'b0;
      ap_start_q <= 1'b0;
    end else begin
      case (state_q)
        KCTRL_IDLE: begin
          done_q <= 1'b0;
          if (ctrl_i.start && ctrl_i.enable) begin
            cnt_q   <= '0;
            limit_q <= CW'(ctrl_i.cnt_limit_y_V);
            if (ctrl_i.cnt_limit_y_V == '0) begin
              // Empty job: report done without ever starting the kernel.
              state_q <= KCTRL_DONE;
              done_q  <= 1'b1;
            end else begin
              state_q    <= KCTRL_RUN;
              ap_start_q <= 1'b1;
            end
          end
        end
        KCTRL_RUN: begin
          // ap_start held as a level so the kernel auto-restarts until the limit.
          ap_start_q <= ctrl_i.enable;
          if (y_hs) begin
            cnt_q <= cnt_inc;
            if (cnt_inc == limit_q) begin
              ap_start_q <= 1'b0;
              done_q     <= 1'b1;
              state_q    <= KCTRL_DONE;
            end
          end
        end
        KCTRL_DONE: begin
          done_q     <= 1'b0;
          ap_start_q <= 1'b0;
          state_q    <= KCTRL_IDLE;
        end
        default: state_q <= KCTRL_IDLE;
      endcase
    end
  end

endmodule

// File: doc/fir_128_mdc_kernel_ctrl.md
Name: fir_128_mdc_kernel_ctrl

Overview:
- Engine-side responder to the FIR_128_MDC control FSM. Consumes ctrl_engine_t (clear/enable/start/cnt_limit_y_V) and returns flags_engine_t (cnt_y_V/done/ready).
- Drives the HLS ap_ctrl_hs handshake (ap_start/ap_done/ap_idle/ap_ready) of the FIR kernel.
- Bridges the kernel's ap_fifo ports to the HWPE x_V (sink) and y_V (source) streams.
- Counts delivered y_V beats and terminates the job at the programmed limit.

Parameters:
- DATA_WIDTH, 32, width of the x_V/y_V data buses.
- CNT_LEN, FIR_128_MDC_CNT_LEN (1024), maximum count; counter width CW = $clog2(CNT_LEN)+1 = 11.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous reset, active-low
- ctrl_i  in  ctrl_engine_t  clear/enable/start/cnt_limit_y_V
- flags_o  out  flags_engine_t  cnt_y_V/done/ready
- x_V_i  sink  hwpe_stream_intf_stream (DATA_WIDTH)  input stream from the streamer
- y_V_o  source  hwpe_stream_intf_stream (DATA_WIDTH)  output stream to the streamer
- ap_rst_o  out  1  kernel reset, active-high, equals ~rst_ni | ctrl_i.clear
- ap_start_o  out  1  kernel start
- ap_done_i, ap_idle_i, ap_ready_i  in  1 each  kernel status
- x_V_dout_o  out  DATA_WIDTH  kernel input data
- x_V_empty_n_o  out  1  kernel input FIFO non-empty
- x_V_read_i  in  1  kernel input read strobe
- y_V_din_i  in  DATA_WIDTH  kernel output data
- y_V_full_n_o  out  1  kernel output FIFO not full
- y_V_write_i  in  1  kernel output write strobe

Behaviour:
- Reset (rst_ni=0, async):
  - state=IDLE, cnt=0, done_q=0, ap_start_o=0.
  - Streams idle: x_V_i.ready=0, y_V_o.valid=0.
  - Any in-flight job is abandoned.
- ctrl_i.clear (synchronous, highest priority): same effect as reset. ap_rst_o is high for that cycle.
- States: IDLE, RUN, DONE.
- IDLE:
  - flags_o.ready = ap_idle_i.
  - On start=1 and enable=1: cnt<=0 and limit_q<=cnt_limit_y_V.
  - If cnt_limit_y_V=0, go to DONE without asserting ap_start; otherwise go to RUN.
  - start with enable=0 is ignored.
- RUN:
  - ap_start_o = enable (registered level, held high for HLS auto-restart).
  - If ap_done_i arrives with cnt<limit_q, the kernel restarts automatically; no extra action.
  - Each y_V_o handshake (valid&ready) increments cnt.
  - When the increment makes cnt==limit_q: ap_start_o<=0 and go to DONE.
  - start while in RUN is ignored. flags_o.ready=0.
- DONE: flags_o.done=1 for exactly one cycle (the cycle after the final handshake), then go to IDLE. cnt holds until the next start or clear.
- flags_o.cnt_y_V = cnt (CW bits, unsigned, never wraps; saturation is impossible because limit ≤ CNT_LEN).
- Stream bridging, all gated by enable:
  - x_V_dout_o = x_V_i.data.
  - x_V_empty_n_o = x_V_i.valid & enable & (state==RUN).
  - x_V_i.ready = x_V_read_i & enable & (state==RUN).
  - x_V_i.strb is ignored.
- enable=0 in RUN: both streams stalled, cnt frozen, ap_start_o<=0. Resumes without loss when enable returns.
- Beats written by the kernel after the limit is reached: y_V_full_n_o=0 outside RUN, so these beats are never accepted.
- Simultaneous start and clear: clear wins.

Optional Feature:
- Macro: FIR_128_MDC_Y_V_SKID_EN.
- Defined:
  - y_V passes through a 2-entry skid buffer, so y_V_o.valid/data are registered.
  - y_V_full_n_o = buffer not full.
  - Latency from kernel write to y_V_o.valid is 1 cycle; full throughput is kept.
  - DONE is reached only after the buffer drains, because counting happens on y_V_o handshakes.
  - clear empties the buffer.
- Undefined:
  - y_V_o.data = y_V_din_i.
  - y_V_o.valid = y_V_write_i & enable & (state==RUN).
  - y_V_full_n_o = y_V_o.ready & enable & (state==RUN).
  - Zero latency.

Decomposition:
- fir_128_mdc_package: add state_kctrl_t enum (KCTRL_IDLE, KCTRL_RUN, KCTRL_DONE) and localparam FIR_128_MDC_CNT_W. ctrl_engine_t and flags_engine_t are reused unchanged.
- Sub-module fir_128_mdc_y_V_skid (2-entry valid/ready skid buffer, DATA_WIDTH), instantiated only under the macro.

Test Plan:
- Reset then idle: rst_ni low mid-RUN with cnt=5 -> next cycle cnt_y_V=0, ap_start_o=0, y_V_o.valid=0, done=0; flags_o.ready follows ap_idle_i=1.
- Nominal job: limit=8, start pulse, kernel echoes 8 beats with y_V_o.ready=1 -> cnt_y_V steps 1..8; done high one cycle after the 8th handshake; ap_start_o falls the same cycle; a 9th kernel write is not accepted.
- Backpressure: limit=4, y_V_o.ready toggles 1/0 every cycle -> no beat lost or duplicated; output data equals the kernel data order; done after the 4th accepted beat.
- enable low for 10 cycles mid-job at cnt=3 -> x_V_i.ready=0, y_V_o.valid=0, cnt stays 3; job completes normally after enable is restored.
- limit=0 start -> done pulse on the 2nd cycle, ap_start_o never high. Clear asserted together with start -> state stays IDLE and ap_rst_o=1 that cycle.
- With FIR_128_MDC_Y_V_SKID_EN: limit=16, continuous ready -> one beat per cycle after a 1-cycle latency; done follows the 16th output handshake. Clear with 2 entries buffered -> y_V_o.valid=0 next cycle.
